regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Write-side controller for the 32x32 register file: the only block that drives its write port (A3, WD3, EN).
- After reset it sweeps x1..x31 to a known value, because the register file itself has no reset.
- In run mode it accepts writeback requests from the execute/memory stage over a valid/ready handshake and buffers them in a small FIFO.
- It applies RV32I load extension, suppresses writes to x0, and exposes the in-flight write for decode-stage forwarding.

Parameters:
- DEPTH, 2, writeback FIFO entries (power of two, >=2).
- INIT_VALUE, 32'h0000_0000, value written to x1..x31 during the init sweep.
- SKIP_INIT, 0, 1 = bypass the sweep and enter RUN directly after reset.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  writeback request valid.
- IN_READY  out  1  request accepted this cycle when IN_VALID && IN_READY.
- IN_RD  in  5  destination register.
- IN_DATA  in  32  ALU result or raw memory word.
- IN_IS_LOAD  in  1  1 = apply load extension.
- IN_FUNCT3  in  3  load funct3 (valid only when IN_IS_LOAD=1).
- IN_ADDR_LO  in  2  load address bits [1:0].
- HOLD  in  1  freeze FIFO pops while in RUN.
- A3  out  5  register file write address.
- WD3  out  32  register file write data.
- EN  out  1  register file write enable.
- INIT_DONE  out  1  high once in RUN.
- FWD_VALID  out  1  equals EN.
- FWD_RD  out  5  equals A3.
- FWD_DATA  out  32  equals WD3.

Behaviour:
- Reset (async, RST_N=0):
  - EN=0, A3=0, WD3=0, INIT_DONE=0, IN_READY=0.
  - FIFO emptied (pointers/count=0); sweep counter=1.
  - State = INIT, or RUN if SKIP_INIT=1.
  - Assertion mid-sweep or mid-stream discards everything; the sweep restarts from x1.
- FSM states: INIT, RUN.
- INIT:
  - Each cycle registers EN=1, A3=cnt, WD3=INIT_VALUE, then cnt++.
  - After the edge that registers A3=31, the next state is RUN. The sweep takes exactly 31 cycles.
  - HOLD and IN_VALID are ignored; IN_READY=0.
- RUN:
  - INIT_DONE=1 (registered, rises on the cycle after the last sweep write is issued).
  - IN_READY = INIT_DONE && (count < DEPTH), purely from registered state; no combinational path from pop, HOLD or IN_VALID.
  - Push on IN_VALID && IN_READY: store {rd, data, is_load, funct3, addr_lo}.
- Pop, every edge where count>0 && !HOLD:
  - Register A3=rd and WD3=ext(data).
  - Register EN=1 if rd!=0; EN=0 if rd=0 (entry consumed, write dropped).
  - With no pop: EN=0; A3 and WD3 hold their previous values.
- Latency: accept at edge k -> EN/A3/WD3 valid after edge k+1 -> register file written at edge k+2.
- Simultaneous push and pop in the same edge is legal; count is unchanged.
- Ordering is strictly FIFO; no reordering or merging of writes to the same rd.
- Load extension, applied at pop:
  - funct3 000 LB: sign-extend byte data[8*addr_lo +: 8].
  - funct3 001 LH: sign-extend half data[16*addr_lo[1] +: 16]; addr_lo[0] ignored.
  - funct3 100 LBU and 101 LHU: zero-extend the same selections.
  - funct3 010 LW and all other codes: data unchanged.
  - IN_IS_LOAD=0: data unchanged regardless of funct3.
- Boundaries:
  - Full FIFO with HOLD=1: IN_READY=0 until a pop occurs.
  - FIFO pointers wrap modulo DEPTH.
  - HOLD deasserting with a full FIFO drains one entry per cycle.
- Forwarding: FWD_* are the registered write-port values themselves, so decode may bypass the same-cycle write.

Test Plan:
- Reset release, SKIP_INIT=0 -> EN=1 for 31 consecutive cycles with A3=1..31 and WD3=0; INIT_DONE rises on the next cycle; IN_READY=0 throughout the sweep.
- RUN, push rd=5, data=32'hDEAD_BEEF, IN_IS_LOAD=0 -> one cycle later EN=1, A3=5, WD3=32'hDEAD_BEEF, FWD_* identical; EN=0 on the following cycle.
- Load data=32'h8077_F0A5:
  - LB addr_lo=0 -> WD3=32'hFFFF_FFA5.
  - LBU addr_lo=1 -> 32'h0000_00F0.
  - LH addr_lo=2 -> 32'hFFFF_8077.
  - LHU addr_lo=3 -> 32'h0000_8077.
  - LW -> 32'h8077_F0A5.
- Push rd=0 data=32'h1234 -> entry consumed, EN stays 0, next entry issues on the following cycle.
- HOLD=1, push rd=1,2 (DEPTH=2) -> IN_READY=0 after the second accept; release HOLD -> writes to x1 then x2 on consecutive cycles, IN_READY=1 again one cycle after the first pop.
- RST_N pulsed low during sweep at A3=17 and with one FIFO entry queued -> outputs zero immediately, entry lost, sweep restarts at A3=1.

Source files
------------

// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Brief    : Register-file write-port controller: post-reset init sweep of
//            x1..x31, buffered writeback FIFO, RV32I load extension, x0 drop.
// Revision : 1.0
// ============================================================================
module regfile_writeback #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
    parameter bit          SKIP_INIT  = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [4:0]  IN_RD,
    input  logic [31:0] IN_DATA,
    input  logic        IN_IS_LOAD,
    input  logic [2:0]  IN_FUNCT3,
    input  logic [1:0]  IN_ADDR_LO,
    input  logic        HOLD,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        EN,
    output logic        INIT_DONE,
    output logic        FWD_VALID,
    output logic [4:0]  FWD_RD,
    output logic [31:0] FWD_DATA
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        is_load;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
    } entry_t;

    state_t           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             init_done_q, init_done_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           mem_q [DEPTH];
    entry_t           head;
    entry_t           in_entry;
    logic             push;
    logic             pop;

    function automatic logic [31:0] load_ext(input entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(e.data >> {e.addr_lo, 3'b000});
        h = 16'(e.data >> {e.addr_lo[1], 4'b0000});
        r = e.data;
        if (e.is_load) begin
            case (e.funct3)
                3'b000:  r = {{24{b[7]}}, b};
                3'b001:  r = {{16{h[15]}}, h};
                3'b100:  r = {24'h0, b};
                3'b101:  r = {16'h0, h};
                default: r = e.data;
            endcase
        end
        return r;
    endfunction

    // Ready depends only on registered state so upstream sees no comb path.
    assign IN_READY = init_done_q && (count_q < DEPTH_C);

    assign in_entry = '{rd: IN_RD, data: IN_DATA, is_load: IN_IS_LOAD,
                        funct3: IN_FUNCT3, addr_lo: IN_ADDR_LO};
    assign head     = mem_q[rd_ptr_q];
    assign push     = IN_VALID && IN_READY;
    assign pop      = (state_q == ST_RUN) && (count_q != '0) && !HOLD;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_d        = 1'b0;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        init_done_d = (state_q == ST_RUN);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        case (state_q)
            ST_INIT: begin
                en_d  = 1'b1;
                a3_d  = cnt_q;
                wd3_d = INIT_VALUE;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (pop) begin
                    // x0 entries are consumed but never reach the write port.
                    en_d  = (head.rd != 5'd0);
                    a3_d  = head.rd;
                    wd3_d = load_ext(head);
                end
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= SKIP_INIT ? ST_RUN : ST_INIT;
            cnt_q       <= 5'd1;
            en_q        <= 1'b0;
            a3_q        <= 5'd0;
            wd3_q       <= 32'd0;
            init_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            init_done_q <= init_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the reset pointers.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign EN        = en_q;
    assign A3        = a3_q;
    assign WD3       = wd3_q;
    assign INIT_DONE = init_done_q;
    assign FWD_VALID = en_q;
    assign FWD_RD    = a3_q;
    assign FWD_DATA  = wd3_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Brief    : Scoreboard bench for regfile_writeback (sweep, writeback, loads,
//            x0 drop, HOLD back-pressure, asynchronous reset mid-operation).
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback;

    logic        CLK        = 1'b0;
    logic        RST_N      = 1'b0;
    logic        IN_VALID   = 1'b0;
    logic [4:0]  IN_RD      = 5'd0;
    logic [31:0] IN_DATA    = 32'd0;
    logic        IN_IS_LOAD = 1'b0;
    logic [2:0]  IN_FUNCT3  = 3'd0;
    logic [1:0]  IN_ADDR_LO = 2'd0;
    logic        HOLD       = 1'b0;
    logic        IN_READY;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        EN;
    logic        INIT_DONE;
    logic        FWD_VALID;
    logic [4:0]  FWD_RD;
    logic [31:0] FWD_DATA;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_exp;

    always #5 CLK = ~CLK;

    regfile_writeback #(
        .DEPTH      (2),
        .INIT_VALUE (32'h0000_0000),
        .SKIP_INIT  (1'b0)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_RD      (IN_RD),
        .IN_DATA    (IN_DATA),
        .IN_IS_LOAD (IN_IS_LOAD),
        .IN_FUNCT3  (IN_FUNCT3),
        .IN_ADDR_LO (IN_ADDR_LO),
        .HOLD       (HOLD),
        .A3         (A3),
        .WD3        (WD3),
        .EN         (EN),
        .INIT_DONE  (INIT_DONE),
        .FWD_VALID  (FWD_VALID),
        .FWD_RD     (FWD_RD),
        .FWD_DATA   (FWD_DATA)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Every write-port pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RST_N && EN) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got A3=%0d WD3=%h, required no write", A3, WD3);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({A3, WD3} !== mon_exp || {FWD_VALID, FWD_RD, FWD_DATA} !== {1'b1, mon_exp}) begin
                    n_err++;
                    $display("FAIL write_port: got A3=%0d WD3=%h FWD=%b/%0d/%h, required A3=%0d WD3=%h",
                             A3, WD3, FWD_VALID, FWD_RD, FWD_DATA, mon_exp[36:32], mon_exp[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic sweep_expect();
        for (int i = 1; i < 32; i++) begin
            exp_q.push_back({5'(i), 32'h0000_0000});
        end
    endtask

    task automatic run_sweep(input int stop_at);
        for (int c = 1; c <= 31; c++) begin
            @(negedge CLK);
            #1;
            chk("sweep_ready", 32'(IN_READY), 32'd0);
            chk("sweep_a3", 32'(A3), 32'(c));
            chk("sweep_init_done", 32'(INIT_DONE), 32'd0);
            if (c == stop_at) return;
        end
        @(negedge CLK);
        #1;
        chk("init_done_rise", 32'(INIT_DONE), 32'd1);
        chk("post_sweep_en", 32'(EN), 32'd0);
        chk("ready_after_init", 32'(IN_READY), 32'd1);
    endtask

    task automatic push(input logic [4:0] rd, input logic [31:0] d, input logic ld,
                        input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] exp_wd);
        int   t;
        logic ok;
        t          = 0;
        ok         = 1'b0;
        IN_RD      = rd;
        IN_DATA    = d;
        IN_IS_LOAD = ld;
        IN_FUNCT3  = f3;
        IN_ADDR_LO = alo;
        IN_VALID   = 1'b1;
        forever begin
            ok = IN_READY;
            @(posedge CLK);
            #1;
            if (ok) break;
            t++;
            if (t > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL push_timeout: got no IN_READY in 50 cycles, required acceptance of rd=%0d", rd);
                break;
            end
        end
        IN_VALID = 1'b0;
        if (ok && rd != 5'd0) exp_q.push_back({rd, exp_wd});
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_en"}, 32'(EN), 32'd0);
        chk({tag, "_a3"}, 32'(A3), 32'd0);
        chk({tag, "_wd3"}, WD3, 32'd0);
        chk({tag, "_init_done"}, 32'(INIT_DONE), 32'd0);
        chk({tag, "_ready"}, 32'(IN_READY), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk_zero_outputs("reset");

        @(negedge CLK);
        sweep_expect();
        RST_N = 1'b1;
        run_sweep(0);

        // Plain ALU result; funct3 must be ignored when not a load.
        push(5'd5, 32'hDEAD_BEEF, 1'b0, 3'b000, 2'd1, 32'hDEAD_BEEF);
        tick();
        chk("single_en", 32'(EN), 32'd1);
        chk("single_fwd_rd", 32'(FWD_RD), 32'd5);
        tick();
        chk("single_en_clear", 32'(EN), 32'd0);

        // Back-to-back loads exercise simultaneous push and pop.
        push(5'd10, 32'h8077_F0A5, 1'b1, 3'b000, 2'd0, 32'hFFFF_FFA5);
        push(5'd11, 32'h8077_F0A5, 1'b1, 3'b100, 2'd1, 32'h0000_00F0);
        push(5'd12, 32'h8077_F0A5, 1'b1, 3'b001, 2'd2, 32'hFFFF_8077);
        push(5'd13, 32'h8077_F0A5, 1'b1, 3'b101, 2'd3, 32'h0000_8077);
        push(5'd14, 32'h8077_F0A5, 1'b1, 3'b010, 2'd0, 32'h8077_F0A5);
        repeat (3) tick();

        push(5'd0, 32'h0000_1234, 1'b0, 3'b000, 2'd0, 32'h0000_1234);
        push(5'd7, 32'h0000_0055, 1'b0, 3'b000, 2'd0, 32'h0000_0055);
        chk("x0_dropped_en", 32'(EN), 32'd0);
        tick();
        chk("after_x0_en", 32'(EN), 32'd1);
        chk("after_x0_a3", 32'(A3), 32'd7);
        repeat (2) tick();

        HOLD = 1'b1;
        push(5'd1, 32'h0000_0111, 1'b0, 3'b000, 2'd0, 32'h0000_0111);
        push(5'd2, 32'h0000_0222, 1'b0, 3'b000, 2'd0, 32'h0000_0222);
        chk("full_ready", 32'(IN_READY), 32'd0);
        tick();
        chk("hold_ready", 32'(IN_READY), 32'd0);
        chk("hold_en", 32'(EN), 32'd0);
        HOLD = 1'b0;
        tick();
        chk("drain1_a3", 32'(A3), 32'd1);
        chk("drain1_ready", 32'(IN_READY), 32'd1);
        tick();
        chk("drain2_a3", 32'(A3), 32'd2);
        chk("drain2_en", 32'(EN), 32'd1);
        tick();
        chk("drained_en", 32'(EN), 32'd0);

        // Reset with a queued entry: the entry must never be written.
        HOLD = 1'b1;
        push(5'd9, 32'h0000_0999, 1'b0, 3'b000, 2'd0, 32'h0000_0999);
        tick();
        RST_N = 1'b0;
        #1;
        chk_zero_outputs("rst_queued");
        exp_q.delete();
        HOLD = 1'b0;

        @(negedge CLK);
        sweep_expect();
        RST_N = 1'b1;
        run_sweep(17);
        RST_N = 1'b0;
        #1;
        chk_zero_outputs("rst_sweep");
        exp_q.delete();

        @(negedge CLK);
        sweep_expect();
        RST_N = 1'b1;
        run_sweep(0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lost_entry_en", 32'(EN), 32'd0);
        end

        push(5'd3, 32'h0000_0333, 1'b0, 3'b000, 2'd0, 32'h0000_0333);
        repeat (3) tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
